// File: rtl/tensor_core_pkg.sv
// Shared types and sizing constants for the tensor-core K-loop slice.
package tensor_core_pkg;

  localparam int TILE_ELEMS     = 16;
  localparam int FP16_DWIDTH    = 16;
  localparam int KULISCH_AWIDTH = 91;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } kctrl_state_t;

endpackage

// File: rtl/tensor_core_acc_bank.sv
// 4x4 Kulisch accumulator bank: cleared, initialised from a C tile, or updated
// with the datapath result. Clear wins over init, init wins over update.
module tensor_core_acc_bank
  import tensor_core_pkg::*;
#(
  parameter int AWIDTH = KULISCH_AWIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         load_init,
  input  logic [TILE_ELEMS*AWIDTH-1:0] init_val,
  input  logic                         load_upd,
  input  logic [TILE_ELEMS*AWIDTH-1:0] upd_val,
  output logic [TILE_ELEMS*AWIDTH-1:0] acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (load_init) begin
      acc <= init_val;
    end else if (load_upd) begin
      acc <= upd_val;
    end
  end

endmodule

// File: rtl/tensor_core_kloop_ctrl.sv
// Walks the combinational 4x4 MMA datapath over K/4 tile pairs, feeding the
// accumulator bank back as C_in and handing the final tile downstream.
module tensor_core_kloop_ctrl
  import tensor_core_pkg::*;
#(
  parameter int DWIDTH = FP16_DWIDTH,
  parameter int AWIDTH = KULISCH_AWIDTH,
  parameter int KCW    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [KCW-1:0]               k_tiles,
  input  logic                         bias_en,
  input  logic [TILE_ELEMS*AWIDTH-1:0] c_init,
  output logic                         busy,
  input  logic [TILE_ELEMS*DWIDTH-1:0] a_tile,
  input  logic [TILE_ELEMS*DWIDTH-1:0] b_tile,
  input  logic                         tile_valid,
  output logic                         tile_ready,
  output logic [TILE_ELEMS*DWIDTH-1:0] mma_a,
  output logic [TILE_ELEMS*DWIDTH-1:0] mma_b,
  output logic [TILE_ELEMS*AWIDTH-1:0] mma_c,
  input  logic [TILE_ELEMS*AWIDTH-1:0] mma_c_out,
  output logic [TILE_ELEMS*AWIDTH-1:0] res_data,
  output logic                         res_valid,
  input  logic                         res_ready
);

  kctrl_state_t                  state;
  logic [KCW-1:0]                cnt;
  logic [TILE_ELEMS*AWIDTH-1:0]  acc;
  logic                          start_acc;
  logic                          tile_fire;

  assign start_acc = (state == IDLE) && start;
  assign tile_fire = (state == RUN) && tile_valid;

  tensor_core_acc_bank #(
    .AWIDTH (AWIDTH)
  ) u_acc_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_acc && !bias_en),
    .load_init (start_acc && bias_en),
    .init_val  (c_init),
    .load_upd  (tile_fire),
    .upd_val   (mma_c_out),
    .acc       (acc)
  );

  // Entry into RUN only happens with a non-zero count, so cnt >= 1 on every decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= k_tiles;
            state <= (k_tiles != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (tile_valid) begin
            cnt <= cnt - KCW'(1);
            if (cnt == KCW'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign tile_ready = (state == RUN);
  assign res_valid  = (state == DONE);
  assign res_data   = (state == DONE) ? acc : '0;

  // Operands are held at zero outside RUN so the datapath does not toggle.
  assign mma_a = (state == RUN) ? a_tile : '0;
  assign mma_b = (state == RUN) ? b_tile : '0;
  assign mma_c = acc;

endmodule

// File: tb/tb_tensor_core_kloop_ctrl.sv
// Directed bench for tensor_core_kloop_ctrl using a stub datapath (C_out = C_in + 1 per element).
module tb_tensor_core_kloop_ctrl;

  localparam int DW  = 16;
  localparam int AW  = 91;
  localparam int KCW = 8;
  localparam int NE  = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [KCW-1:0]    k_tiles;
  logic              bias_en;
  logic [NE*AW-1:0]  c_init;
  logic              busy;
  logic [NE*DW-1:0]  a_tile;
  logic [NE*DW-1:0]  b_tile;
  logic              tile_valid;
  logic              tile_ready;
  logic [NE*DW-1:0]  mma_a;
  logic [NE*DW-1:0]  mma_b;
  logic [NE*AW-1:0]  mma_c;
  logic [NE*AW-1:0]  mma_c_out;
  logic [NE*AW-1:0]  res_data;
  logic              res_valid;
  logic              res_ready;

  int total;
  int bad;

  tensor_core_kloop_ctrl #(
    .DWIDTH (DW),
    .AWIDTH (AW),
    .KCW    (KCW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .k_tiles    (k_tiles),
    .bias_en    (bias_en),
    .c_init     (c_init),
    .busy       (busy),
    .a_tile     (a_tile),
    .b_tile     (b_tile),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .mma_a      (mma_a),
    .mma_b      (mma_b),
    .mma_c      (mma_c),
    .mma_c_out  (mma_c_out),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    mma_c_out = '0;
    for (int i = 0; i < NE; i++) begin
      mma_c_out[i*AW +: AW] = mma_c[i*AW +: AW] + AW'(1);
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic checkTile(input string tag, input logic [NE*AW-1:0] vec, input logic [NE*AW-1:0] expVec);
    for (int i = 0; i < NE; i++) begin
      checkOutput($sformatf("%s[%0d]", tag, i), 128'(vec[i*AW +: AW]), 128'(expVec[i*AW +: AW]));
    end
  endtask

  function automatic logic [NE*AW-1:0] fillTile(input logic [AW-1:0] v);
    logic [NE*AW-1:0] t;
    for (int i = 0; i < NE; i++) begin
      t[i*AW +: AW] = v;
    end
    return t;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [KCW-1:0] kt, input logic be, input logic [NE*AW-1:0] ci);
    start   = 1'b1;
    k_tiles = kt;
    bias_en = be;
    c_init  = ci;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    int readyCnt;
    int cyc;
    logic [NE*AW-1:0] ci;

    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    k_tiles    = '0;
    bias_en    = 1'b0;
    c_init     = '0;
    a_tile     = '0;
    b_tile     = '0;
    tile_valid = 1'b0;
    res_ready  = 1'b1;

    #2;
    checkOutput("rst_busy", 128'(busy), 128'd0);
    checkOutput("rst_tile_ready", 128'(tile_ready), 128'd0);
    checkOutput("rst_res_valid", 128'(res_valid), 128'd0);
    checkOutput("rst_acc0", 128'(mma_c[0 +: AW]), 128'd0);
    #10;
    rst_n = 1'b1;
    tick();

    // Job 1: three tiles streamed back to back, zero init
    $display("[TB] job1 k=3 bias=0 streaming");
    tile_valid = 1'b1;
    applyStimulus(8'd3, 1'b0, '0);
    readyCnt = 0;
    cyc = 1;
    while (!res_valid && cyc < 20) begin
      if (tile_ready) readyCnt++;
      tick();
      cyc++;
    end
    checkOutput("j1_ready_cycles", 128'(readyCnt), 128'd3);
    checkOutput("j1_latency", 128'(cyc), 128'd4);
    checkTile("j1_res", res_data, fillTile(AW'(3)));
    tile_valid = 1'b0;
    tick();
    checkOutput("j1_idle_busy", 128'(busy), 128'd0);

    // Job 2: bias init 100, producer gap between the two tiles
    $display("[TB] job2 k=2 bias=1 with stall");
    a_tile = {NE{16'h1234}};
    b_tile = {NE{16'hABCD}};
    applyStimulus(8'd2, 1'b1, fillTile(AW'(100)));
    checkOutput("j2_mma_a_run", 128'(mma_a[0 +: DW]), 128'h1234);
    checkOutput("j2_mma_b_run", 128'(mma_b[15*DW +: DW]), 128'hABCD);
    tile_valid = 1'b1;
    tick();
    checkOutput("j2_acc_after1", 128'(mma_c[0 +: AW]), 128'd101);
    tile_valid = 1'b0;
    tick();
    checkOutput("j2_stall_busy", 128'(busy), 128'd1);
    checkOutput("j2_stall_valid", 128'(res_valid), 128'd0);
    checkOutput("j2_stall_acc", 128'(mma_c[5*AW +: AW]), 128'd101);
    tile_valid = 1'b1;
    tick();
    tile_valid = 1'b0;
    checkOutput("j2_res_valid", 128'(res_valid), 128'd1);
    checkTile("j2_res", res_data, fillTile(AW'(102)));
    checkOutput("j2_mma_a_done", 128'(mma_a[0 +: DW]), 128'd0);
    tick();
    checkOutput("j2_mma_b_idle", 128'(mma_b[0 +: DW]), 128'd0);

    // Job 3: zero-length job returns the bias tile directly
    $display("[TB] job3 k=0 bias=1");
    ci = '0;
    ci[11*AW +: AW] = AW'(7);
    tile_valid = 1'b1;
    applyStimulus(8'd0, 1'b1, ci);
    checkOutput("j3_res_valid", 128'(res_valid), 128'd1);
    checkOutput("j3_tile_ready", 128'(tile_ready), 128'd0);
    checkTile("j3_res", res_data, ci);
    tile_valid = 1'b0;
    tick();
    checkOutput("j3_idle_busy", 128'(busy), 128'd0);

    // Job 4: starts during RUN/DONE ignored, result held under back-pressure
    $display("[TB] job4 k=2 back-pressure");
    res_ready = 1'b0;
    applyStimulus(8'd2, 1'b0, '0);
    start      = 1'b1;
    k_tiles    = 8'd5;
    tile_valid = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tile_valid = 1'b0;
    checkOutput("j4_done_after2", 128'(res_valid), 128'd1);
    for (int i = 0; i < 5; i++) begin
      start   = (i == 2);
      k_tiles = 8'd0;
      checkOutput($sformatf("j4_hold_valid%0d", i), 128'(res_valid), 128'd1);
      checkOutput($sformatf("j4_hold_data%0d", i), 128'(res_data[3*AW +: AW]), 128'd2);
      tick();
    end
    start = 1'b0;
    checkTile("j4_res", res_data, fillTile(AW'(2)));
    res_ready = 1'b1;
    start     = 1'b1;
    k_tiles   = 8'd1;
    tick();
    start = 1'b0;
    checkOutput("j4_accept_busy", 128'(busy), 128'd0);
    checkOutput("j4_accept_valid", 128'(res_valid), 128'd0);
    tick();
    checkOutput("j4_handshake_start_ignored", 128'(busy), 128'd0);

    // Job 5: reset after the first of three tiles, then a fresh single-tile job
    $display("[TB] job5 reset mid-job");
    tile_valid = 1'b1;
    applyStimulus(8'd3, 1'b0, '0);
    tick();
    checkOutput("j5_acc_before_rst", 128'(mma_c[0 +: AW]), 128'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("j5_rst_tile_ready", 128'(tile_ready), 128'd0);
    checkOutput("j5_rst_res_valid", 128'(res_valid), 128'd0);
    checkOutput("j5_rst_busy", 128'(busy), 128'd0);
    checkOutput("j5_rst_acc", 128'(mma_c[0 +: AW]), 128'd0);
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("j5_post_rst_idle", 128'(busy), 128'd0);
    applyStimulus(8'd1, 1'b0, '0);
    tick();
    tile_valid = 1'b0;
    checkOutput("j5_new_valid", 128'(res_valid), 128'd1);
    checkTile("j5_new_res", res_data, fillTile(AW'(1)));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tensor_core_kloop_ctrl.md
Name: tensor_core_kloop_ctrl

Overview:
- Sequences the combinational 4x4 FP16 MMA datapath (C_out = A*B + C_in, Kulisch accumulators) over the K dimension.
- Accepts a stream of K/4 A/B tile pairs and holds a 4x4 Kulisch accumulator bank. Feeds the bank back as C_in every step and emits the final accumulator tile through a valid/ready handshake.
- Sits between the tile fetch/DMA front end and the result normaliser.

Parameters:
- DWIDTH, 16, element width of A/B (FP16).
- AWIDTH, 91, Kulisch accumulator width per C element.
- KCW, 8, width of the K-tile count; max 2^KCW-1 tiles per job.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job start pulse; sampled only in IDLE.
- k_tiles  in  KCW  number of A/B tile pairs in the job; sampled with start.
- bias_en  in  1  1: init accumulators from c_init; 0: init to zero; sampled with start.
- c_init  in  16*AWIDTH  initial C tile, element (i,j) at bits [(i*4+j)*AWIDTH +: AWIDTH].
- busy  out  1  high whenever state != IDLE.
- a_tile  in  16*DWIDTH  A tile, same (i,j) packing.
- b_tile  in  16*DWIDTH  B tile.
- tile_valid  in  1  A/B tile pair valid.
- tile_ready  out  1  controller accepts a tile pair this cycle.
- mma_a  out  16*DWIDTH  to datapath A_in.
- mma_b  out  16*DWIDTH  to datapath B_in.
- mma_c  out  16*AWIDTH  to datapath C_in (accumulator bank).
- mma_c_out  in  16*AWIDTH  from datapath C_out.
- res_data  out  16*AWIDTH  final accumulator tile.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; accumulator bank, tile counter and res_data all cleared to 0.
  - tile_ready=0, res_valid=0, busy=0.
  - Reset mid-job aborts the job. No partial result is emitted.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, load acc <= bias_en ? c_init : 0, load cnt <= k_tiles, and latch nothing else.
  - Next state is RUN if k_tiles!=0, else DONE.
- RUN:
  - tile_ready=1.
  - mma_a=a_tile and mma_b=b_tile, passed through combinationally. mma_c=acc always.
  - On tile_valid && tile_ready, acc <= mma_c_out and cnt <= cnt-1.
  - When the accepted tile has cnt==1, go to DONE.
  - tile_valid=0 stalls the job indefinitely with no state change.
- DONE:
  - res_valid=1, res_data=acc, tile_ready=0.
  - On res_ready=1, return to IDLE.
  - res_data and res_valid are stable while res_valid && !res_ready.
- Latency:
  - Result is valid the cycle after the last tile handshake.
  - A k_tiles=0 job is valid the cycle after start.
  - Throughput is 1 tile per cycle when the producer streams.
- Start rules:
  - start outside IDLE is ignored and has no effect on counters.
  - start in the same cycle as the DONE->IDLE handshake is ignored; the next start must arrive in IDLE.
- Arithmetic:
  - No arithmetic in the controller; all math is in the datapath. Kulisch overflow wraps in the datapath and is not detected here.
  - cnt never underflows: decrement happens only in RUN with cnt>=1.
- Outputs outside RUN:
  - mma_a and mma_b are driven 0 outside RUN to avoid toggling the datapath.
  - mma_c always reflects acc.

Decomposition:
- Shared package tensor_core_pkg holds:
  - typedef kctrl_state_t with IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - localparams TILE_ELEMS=16, FP16_DWIDTH=16, KULISCH_AWIDTH=91.
- One natural sub-module: tensor_core_acc_bank, the 16xAWIDTH accumulator register with load-init/load-update/clear controls.
- The top holds the FSM and counter.

Test Plan:
- Stub datapath (mma_c_out = mma_c + 1 per element), bias_en=0, k_tiles=3, tile_valid held 1 -> tile_ready high 3 cycles; res_valid on the 4th cycle after start; every res_data element = 3.
- Same stub, bias_en=1, c_init all elements 100, k_tiles=2, tile_valid toggling 1,0,1 -> 2 handshakes over 3 cycles; res_data elements = 102; no handshake counted while tile_valid=0.
- k_tiles=0, bias_en=1, c_init element(2,3)=7, others 0 -> res_valid one cycle after start; res_data(2,3)=7, others 0; tile_ready never asserted.
- Result back-pressure: res_ready=0 for 5 cycles, then 1 -> res_valid and res_data stable for 5 cycles; IDLE and busy=0 the cycle after acceptance. start pulses during RUN/DONE are ignored (cnt unchanged).
- Real datapath, A=identity (16'h3C00 on diagonal), B=all 16'h4000 (2.0), k_tiles=4, bias_en=0 -> each res_data element equals the Kulisch encoding of 8.0.
- Assert rst_n=0 after the 1st of 3 tiles -> immediately tile_ready=0, res_valid=0, busy=0, acc=0. A following job with k_tiles=1 on the stub yields elements = 1.
